// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-layer datapath blocks.
package nn_pkg;

    // Default layer geometry: neurons per layer and word width.
    localparam int NN_SIZE  = 3;
    localparam int NN_DEPTH = 16;

    // Width of a counter that must hold the values 0..NN_SIZE inclusive.
    localparam int CNT_W = $clog2(NN_SIZE + 1);

    typedef logic signed [NN_DEPTH-1:0] word_t;
    typedef word_t [NN_SIZE-1:0]         vec_t;

endpackage

// File: rtl/nn_relu.sv
// Combinational ReLU: negative two's-complement words become zero.
// With ENABLE=0 the word passes through untouched.
module nn_relu #(
    parameter int DEPTH  = 16,
    parameter int ENABLE = 1
) (
    input  logic [DEPTH-1:0] din,
    output logic [DEPTH-1:0] dout
);

    // Clamp on the sign bit only; no arithmetic, so no width growth.
    assign dout = ((ENABLE != 0) && din[DEPTH-1]) ? '0 : din;

endmodule

// File: rtl/layer_output_collector.sv
// Collects SIZE serial layer outputs into one vector and presents it over a
// valid/ready handshake. A second (fill) buffer keeps collecting while a
// finished vector waits in the output register.
module layer_output_collector
    import nn_pkg::*;
#(
    parameter int SIZE  = NN_SIZE,
    parameter int DEPTH = NN_DEPTH,
    parameter int RELU  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       y_valid,
    input  logic [DEPTH-1:0]           y_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [SIZE*DEPTH-1:0]      out_data,
    output logic [$clog2(SIZE+1)-1:0]  fill_cnt,
    output logic                       overflow
);

    localparam int CW = $clog2(SIZE + 1);

    logic [SIZE-1:0][DEPTH-1:0] fill;      // fill buffer, element i = word i
    logic [SIZE-1:0][DEPTH-1:0] vec_done;  // fill buffer with this cycle's word merged in
    logic [DEPTH-1:0]           word_f;    // incoming word after optional ReLU
    logic                       pending;   // fill buffer holds a complete vector
    logic                       accept;
    logic                       completes;
    logic                       drain;
    logic                       out_free;

    nn_relu #(
        .DEPTH  (DEPTH),
        .ENABLE (RELU)
    ) u_relu (
        .din  (y_in),
        .dout (word_f)
    );

    // pending is sampled before the update, so a word arriving on a draining
    // edge is still dropped.
    assign accept    = y_valid && !pending;
    assign completes = accept && (fill_cnt == CW'(SIZE - 1));
    assign drain     = out_valid && out_ready;
    assign out_free  = !out_valid || out_ready;

    // Vector as it will look once the current word lands in its slot.
    always_comb begin
        // NOTE: default first so every path assigns vec_done and no latch is inferred.
        vec_done = fill;
        for (int i = 0; i < SIZE; i++) begin
            if (CW'(i) == fill_cnt) begin
                vec_done[i] = word_f;
            end
        end
    end

    // Fill buffer data: write the accepted word into its arrival slot.
    // NOTE: data storage has no reset; fill_cnt and pending alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < SIZE; i++) begin
                if (CW'(i) == fill_cnt) begin
                    fill[i] <= word_f;
                end
            end
        end
    end

    // Fill control, output register, handshake and sticky overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            fill_cnt  <= '0;
            overflow  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (y_valid && pending) begin
                overflow <= 1'b1;
            end

            if (completes) begin
                if (out_free) begin
                    out_data  <= vec_done;
                    out_valid <= 1'b1;
                    fill_cnt  <= '0;
                end else begin
                    pending  <= 1'b1;
                    fill_cnt <= CW'(SIZE);
                end
            end else if (accept) begin
                fill_cnt <= fill_cnt + CW'(1);
            end else if (pending && drain) begin
                // Held vector moves up; out_valid stays high with no bubble.
                out_data <= fill;
                pending  <= 1'b0;
                fill_cnt <= '0;
            end

            if (drain && !pending && !completes) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
